// File: rtl/alloc_req_ctl.sv
// alloc_req_ctl -- per-input-port requester for the M-N match allocator.
//
// Accepts a packet header, raises a request row towards the allocator, and
// waits for a grant on one of the acceptable resources. It then streams the
// packet's flits straight through to the crossbar, drops the request after the
// tail flit, and waits for the grant to fall. This is a four-phase
// req/gnt handshake, and the request never drops before the grant is used.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   hdr_vld/hdr_rdy       header handshake; hdr_mask = acceptable resources,
//                         hdr_len = flit count minus one
//   req [M]               request row to allocator (registered)
//   gnt [M]               grant column from allocator
//   sel [M]               one-hot resource currently owned, 0 when none
//   fi_vld/fi_rdy/fi_data upstream flit handshake
//   fo_vld/fo_rdy/fo_data downstream (crossbar) flit handshake, zero latency
//   fo_tail               last flit of packet
//   err                   one-cycle protocol-violation pulse
module alloc_req_ctl #(
  parameter int M  = 2,
  parameter int DW = 32,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hdr_vld,
  output logic          hdr_rdy,
  input  logic [M-1:0]  hdr_mask,
  input  logic [LW-1:0] hdr_len,
  output logic [M-1:0]  req,
  input  logic [M-1:0]  gnt,
  output logic [M-1:0]  sel,
  input  logic          fi_vld,
  output logic          fi_rdy,
  input  logic [DW-1:0] fi_data,
  output logic          fo_vld,
  input  logic          fo_rdy,
  output logic [DW-1:0] fo_data,
  output logic          fo_tail,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;

  state_t        state;
  logic [M-1:0]  mask_q;
  logic [LW-1:0] cnt;
  logic          drop_seen;   // grant-loss already flagged for this packet

  logic [M-1:0]  v, v_low;
  logic          multi, in_xfer, beat;

  // Only grants on resources we asked for count.
  assign v       = gnt & mask_q;
  // Two's-complement trick isolates the lowest set bit.
  assign v_low   = v & (~v + M'(1));
  assign multi   = |(v & ~v_low);

  // Flit path is combinational so streaming adds no latency.
  assign in_xfer = (state == XFER);
  assign fo_vld  = in_xfer & fi_vld;
  assign fi_rdy  = in_xfer & fo_rdy;
  assign fo_data = fi_data;
  assign fo_tail = in_xfer && (cnt == '0);
  assign beat    = in_xfer & fi_vld & fo_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      req       <= '0;
      sel       <= '0;
      hdr_rdy   <= 1'b0;
      err       <= 1'b0;
      cnt       <= '0;
      mask_q    <= '0;
      drop_seen <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          hdr_rdy <= 1'b1;
          if (hdr_vld && hdr_rdy) begin
            mask_q <= hdr_mask;
            cnt    <= hdr_len;
            // An empty mask can never be served: consume and flag it.
            if (hdr_mask == '0) begin
              err <= 1'b1;
            end else begin
              state   <= REQ;
              req     <= hdr_mask;
              hdr_rdy <= 1'b0;
            end
          end
        end
        REQ: begin
          if (v != '0) begin
            sel       <= v_low;
            state     <= XFER;
            drop_seen <= 1'b0;
            if (multi) err <= 1'b1;
          end
        end
        XFER: begin
          if (!drop_seen && ((gnt & sel) == '0)) begin
            err       <= 1'b1;
            drop_seen <= 1'b1;
          end
          if (beat) begin
            if (cnt == '0) begin
              state <= REL;
              req   <= '0;
              sel   <= '0;
            end else begin
              cnt <= cnt - LW'(1);
            end
          end
        end
        REL: begin
          // Entered with req already low, so req stays low at least one cycle.
          if (v == '0) begin
            state   <= IDLE;
            hdr_rdy <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alloc_req_ctl.sv
// tb_alloc_req_ctl -- randomized self-checking bench for alloc_req_ctl.
// Each packet is driven as a transaction; expected request, owned resource,
// flit order, tail position and error pulses come from the packet's header
// and the chosen grant pattern.
module tb_alloc_req_ctl;
  localparam int M = 2, DW = 32, LW = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          hdr_vld = 1'b0, hdr_rdy;
  logic [M-1:0]  hdr_mask = '0, req, gnt = '0, sel;
  logic [LW-1:0] hdr_len = '0;
  logic          fi_vld = 1'b0, fi_rdy, fo_vld, fo_rdy = 1'b0, fo_tail, err;
  logic [DW-1:0] fi_data = '0, fo_data;

  int n_chk = 0, n_pass = 0, err_seen = 0;

  alloc_req_ctl #(.M(M), .DW(DW), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .hdr_vld(hdr_vld), .hdr_rdy(hdr_rdy),
    .hdr_mask(hdr_mask), .hdr_len(hdr_len), .req(req), .gnt(gnt), .sel(sel),
    .fi_vld(fi_vld), .fi_rdy(fi_rdy), .fi_data(fi_data), .fo_vld(fo_vld),
    .fo_rdy(fo_rdy), .fo_data(fo_data), .fo_tail(fo_tail), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (err === 1'b1) err_seen++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  // One packet. gforce=0 picks a random grant overlapping the mask.
  task automatic run_pkt(input logic [M-1:0] mask, input logic [LW-1:0] len,
                         input bit drop, input logic [M-1:0] gforce);
    logic [M-1:0]  g, v, es;
    logic [DW-1:0] cur;
    int e0, exp_err, k, n, wait_n, hold;
    e0 = err_seen; exp_err = 0;

    hdr_vld = 1'b1; hdr_mask = mask; hdr_len = len;
    gnt = M'($urandom); fi_vld = 1'b1; fo_rdy = 1'b1; fi_data = $urandom;
    @(negedge clk);
    chk("hdr_rdy", hdr_rdy, 1);
    chk("idle_no_flit", {fo_vld, fi_rdy, fo_tail}, 0);
    step;
    hdr_vld = 1'b0;

    if (mask == '0) begin
      gnt = '0;
      @(negedge clk);
      chk("zmask_idle", hdr_rdy, 1);
      chk("zmask_req", req, 0);
      step;
      chk("zmask_err", err_seen - e0, 1);
      return;
    end

    // Grants only outside the mask: must keep requesting, pass nothing.
    wait_n = $urandom_range(1, 3);
    for (int i = 0; i < wait_n; i++) begin
      gnt = M'($urandom) & ~mask; fi_data = $urandom;
      @(negedge clk);
      chk("req_held", req, mask);
      chk("req_hdr_rdy", hdr_rdy, 0);
      chk("req_sel", sel, 0);
      chk("req_no_flit", {fo_vld, fi_rdy}, 0);
      step;
    end

    g = gforce;
    while ((g & mask) == '0) g = M'($urandom);
    v = g & mask;
    es = '0;
    for (int b = M - 1; b >= 0; b--) if (v[b]) begin es = '0; es[b] = 1'b1; end
    if ($countones(v) > 1) exp_err++;
    gnt = g;
    @(negedge clk);
    chk("req_at_gnt", req, mask);
    chk("req_at_gnt_flit", fo_vld, 0);
    step;

    k = 0; n = 0; cur = $urandom;
    if (drop && len != 0) exp_err++;
    while (k <= int'(len) && n < 300) begin
      gnt = (drop && len != 0 && n < 2) ? (g & ~es) : g;
      fi_vld = ($urandom_range(0, 3) != 0);
      fo_rdy = 1'($urandom_range(0, 1));
      fi_data = fi_vld ? cur : DW'($urandom);
      @(negedge clk);
      chk("xfer_sel", sel, es);
      chk("xfer_req", req, mask);
      chk("fo_vld", fo_vld, fi_vld);
      chk("fi_rdy", fi_rdy, fo_rdy);
      chk("fo_tail", fo_tail, (k == int'(len)));
      if (fi_vld) chk("fo_data", fo_data, cur);
      if (fi_vld && fo_rdy) begin k++; cur = $urandom; end
      n++;
      step;
    end
    chk("stream_done", k, int'(len) + 1);

    hold = $urandom_range(0, 2);
    fi_vld = 1'b1; fo_rdy = 1'b1;
    for (int i = 0; i < hold; i++) begin
      gnt = g;
      @(negedge clk);
      chk("rel_req", req, 0);
      chk("rel_sel", sel, 0);
      chk("rel_hdr_rdy", hdr_rdy, 0);
      chk("rel_no_flit", {fo_vld, fi_rdy, fo_tail}, 0);
      step;
    end
    gnt = M'($urandom) & ~mask;
    @(negedge clk);
    chk("rel_req0", req, 0);
    chk("rel_hdr_rdy0", hdr_rdy, 0);
    step;
    @(negedge clk);
    chk("back_idle", hdr_rdy, 1);
    gnt = '0;
    step;
    chk("err_count", err_seen - e0, exp_err);
  endtask

  task automatic reset_mid;
    hdr_vld = 1'b1; hdr_mask = 2'b11; hdr_len = 4'd5; gnt = '0;
    step;
    hdr_vld = 1'b0; gnt = 2'b01;
    step;
    fi_vld = 1'b1; fo_rdy = 1'b1; fi_data = $urandom;
    @(negedge clk);
    chk("pre_rst_vld", fo_vld, 1);
    chk("pre_rst_sel", sel, 2'b01);
    step;
    rst_n = 1'b0;
    step;
    @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_sel", sel, 0);
    chk("rst_flit", {fo_vld, fi_rdy, fo_tail}, 0);
    chk("rst_hdr_rdy", hdr_rdy, 0);
    rst_n = 1'b1; gnt = '0;
    step;
    @(negedge clk);
    chk("rst_idle", hdr_rdy, 1);
    chk("rst_idle_req", req, 0);
    step;
  endtask

  initial begin
    step; step;
    @(negedge clk);
    chk("reset_req", req, 0);
    chk("reset_sel", sel, 0);
    chk("reset_hdr_rdy", hdr_rdy, 0);
    chk("reset_flit", {fo_vld, fo_tail, err}, 0);
    rst_n = 1'b1;
    step;

    run_pkt(2'b01, 4'd2, 1'b0, 2'b01);
    run_pkt(2'b11, 4'd1, 1'b0, 2'b10);
    run_pkt(2'b11, 4'd3, 1'b0, 2'b11);
    run_pkt(2'b01, 4'd1, 1'b0, 2'b01);
    run_pkt(2'b01, 4'd0, 1'b0, 2'b00);
    run_pkt(2'b10, 4'd3, 1'b1, 2'b00);
    run_pkt(2'b00, 4'd2, 1'b0, 2'b00);
    run_pkt(2'b10, 4'd15, 1'b0, 2'b00);
    reset_mid();
    for (int i = 0; i < 40; i++)
      run_pkt(M'($urandom), LW'($urandom), ($urandom_range(0, 3) == 0), '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
